alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Requester/response handshake bundle between two clients and the ALU arbiter.
// The master modport is the requester side; the slave modport is the arbiter.
interface alu_arbiter_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [4:0]   req0_fn;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [4:0]   req1_fn;

    logic         rsp0_valid;
    logic         rsp0_ready;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [N-1:0] rsp_r;
    logic         rsp_z;
    logic         busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_fn,
        output req1_valid, req1_a, req1_b, req1_fn,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_r, rsp_z, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_fn,
        input  req1_valid, req1_a, req1_b, req1_fn,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_r, rsp_z, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared combinational ALU.
// One operation in flight: IDLE -> EXEC (capture ALU) -> RESP (hold until consumed).
module alu_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [4:0]   alu_fn,
    input  logic [N-1:0] alu_r,
    input  logic         alu_z
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [4:0]   op_fn;
    logic         owner;
    logic         last_grant;
    logic [N-1:0] rsp_r_q;
    logic         rsp_z_q;
    logic         rsp0_valid_q;
    logic         rsp1_valid_q;
    logic         busy_q;

    logic rsp_consume;
    logic can_accept;
    logic grant0;
    logic grant1;
    logic accept;

    // Port 1 wins a tie only when port 0 was served last.
    always_comb begin
        rsp_consume = (state == RESP) && (owner ? bus.rsp1_ready : bus.rsp0_ready);
        can_accept  = !reset && ((state == IDLE) || rsp_consume);
        grant1      = bus.req1_valid && (!bus.req0_valid || !last_grant);
        grant0      = bus.req0_valid && !grant1;
        accept      = can_accept && (grant0 || grant1);
    end

    assign bus.req0_ready = can_accept && grant0;
    assign bus.req1_ready = can_accept && grant1;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.busy       = busy_q;

    assign alu_a  = op_a;
    assign alu_b  = op_b;
    assign alu_fn = op_fn;

    // NOTE: async reset clears every register, including the in-flight operand and result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_a         <= '0;
            op_b         <= '0;
            op_fn        <= '0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            rsp_r_q      <= '0;
            rsp_z_q      <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        op_a         <= grant1 ? bus.req1_a  : bus.req0_a;
                        op_b         <= grant1 ? bus.req1_b  : bus.req0_b;
                        op_fn        <= grant1 ? bus.req1_fn : bus.req0_fn;
                        owner        <= grant1;
                        last_grant   <= grant1;
                        state        <= EXEC;
                        busy_q       <= 1'b1;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                    end else if (rsp_consume) begin
                        state        <= IDLE;
                        busy_q       <= 1'b0;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                    end
                end
                EXEC: begin
                    rsp_r_q      <= alu_r;
                    rsp_z_q      <= alu_z;
                    state        <= RESP;
                    rsp0_valid_q <= !owner;
                    rsp1_valid_q <= owner;
                end
                default: begin
                    state        <= IDLE;
                    busy_q       <= 1'b0;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: local ALU model, table of single ops, and hand-written
// sequences for ties, fairness, backpressure, operand changes and reset mid-response.
module tb_alu_arbiter;
    localparam int N = 32;
    localparam logic [4:0] FN_ADD = 5'b00001;
    localparam logic [4:0] FN_SUB = 5'b10001;
    localparam logic [4:0] FN_AND = 5'b00000;
    localparam logic [4:0] FN_OR  = 5'b00100;
    localparam logic [4:0] FN_XOR = 5'b01000;
    localparam logic [4:0] FN_SHL = 5'b00010;
    localparam logic [4:0] FN_SHR = 5'b00110;
    localparam logic [4:0] FN_SRA = 5'b01110;

    typedef struct packed {
        logic         port;
        logic [N-1:0] r;
        logic         z;
    } exp_t;

    typedef struct packed {
        logic         port;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [4:0]   fn;
        logic [N-1:0] r;
        logic         z;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [N-1:0] alu_r;
    logic [4:0]   alu_fn;
    logic         alu_z;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    exp_t sb[$];
    exp_t exp_pend[2];
    logic grant_log[$];
    int   acc_cycle[$];
    logic [1:0] acc_now = 2'b00;

    alu_arbiter_if #(.N(N)) bus ();

    alu_arbiter #(.N(N)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus.slave),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_fn (alu_fn),
        .alu_r  (alu_r),
        .alu_z  (alu_z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    // Shared ALU: fn = {subtract, bool1, bool0, shft, math}.
    always_comb begin
        alu_r = '0;
        if (alu_fn[0]) begin
            alu_r = alu_fn[4] ? alu_a - alu_b : alu_a + alu_b;
        end else if (alu_fn[1]) begin
            case (alu_fn[3:2])
                2'b00:   alu_r = alu_a << alu_b[4:0];
                2'b01:   alu_r = alu_a >> alu_b[4:0];
                default: alu_r = N'($signed(alu_a) >>> alu_b[4:0]);
            endcase
        end else begin
            case (alu_fn[3:2])
                2'b00:   alu_r = alu_a & alu_b;
                2'b01:   alu_r = alu_a | alu_b;
                2'b10:   alu_r = alu_a ^ alu_b;
                default: alu_r = ~(alu_a | alu_b);
            endcase
        end
        alu_z = (alu_r == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_compare(input logic port);
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_port", 64'(port), 64'(e.port));
            check("rsp_r", 64'(bus.rsp_r), 64'(e.r));
            check("rsp_z", 64'(bus.rsp_z), 64'(e.z));
        end
    endtask

    // Monitor on the falling edge: responses popped first, then accepts pushed.
    always @(negedge clk) begin
        acc_now = 2'b00;
        if (!reset) begin
            check("ready_onehot", 64'(bus.req0_ready & bus.req1_ready), 64'd0);
            check("valid_onehot", 64'(bus.rsp0_valid & bus.rsp1_valid), 64'd0);
            if (bus.rsp0_valid && bus.rsp0_ready) pop_compare(1'b0);
            if (bus.rsp1_valid && bus.rsp1_ready) pop_compare(1'b1);
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back(exp_pend[0]);
                grant_log.push_back(1'b0);
                acc_cycle.push_back(cycle);
                acc_now[0] = 1'b1;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back(exp_pend[1]);
                grant_log.push_back(1'b1);
                acc_cycle.push_back(cycle);
                acc_now[1] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic port, input logic [N-1:0] a, input logic [N-1:0] b,
                             input logic [4:0] fn, input logic [N-1:0] er, input logic ez);
        exp_pend[port] = '{port, er, ez};
        if (port) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_fn = fn; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_fn = fn; bus.req0_valid = 1'b1;
        end
    endtask

    task automatic drop_req(input logic port);
        if (port) bus.req1_valid = 1'b0;
        else      bus.req0_valid = 1'b0;
    endtask

    task automatic wait_accept(input logic port);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = acc_now[port];
        end
        check("accept_wait", 64'(got), 64'd1);
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            tick();
            ok = !bus.busy && (sb.size() == 0) && !bus.req0_valid && !bus.req1_valid;
        end
        check("idle_wait", 64'(ok), 64'd1);
    endtask

    task automatic wait_rsp_valid(input logic port);
        logic got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = port ? bus.rsp1_valid : bus.rsp0_valid;
        end
        check("rsp_valid_wait", 64'(got), 64'd1);
    endtask

    // Runs both ports until idle; each port drops its request once accepted.
    task automatic run_both_once();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (acc_now[0]) drop_req(1'b0);
            if (acc_now[1]) drop_req(1'b1);
            if (!bus.req0_valid && !bus.req1_valid && sb.size() == 0 && !bus.busy) break;
        end
        check("both_done", 64'(grant_log.size()), 64'd2);
    endtask

    task automatic clear_logs();
        grant_log.delete();
        acc_cycle.delete();
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1'b0, 32'd5,          32'd3,          FN_ADD, 32'd8,          1'b0};
        vecs[1] = '{1'b1, 32'd7,          32'd7,          FN_SUB, 32'd0,          1'b1};
        vecs[2] = '{1'b0, 32'h0000_00F0,  32'h0000_000F,  FN_OR,  32'h0000_00FF,  1'b0};
        vecs[3] = '{1'b1, 32'h0000_00F0,  32'h0000_000F,  FN_AND, 32'd0,          1'b1};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          FN_ADD, 32'd0,          1'b1};
        vecs[5] = '{1'b1, 32'd0,          32'd1,          FN_SUB, 32'hFFFF_FFFF,  1'b0};
        vecs[6] = '{1'b0, 32'hA5A5_A5A5,  32'hFFFF_FFFF,  FN_XOR, 32'h5A5A_5A5A,  1'b0};
        vecs[7] = '{1'b1, 32'd1,          32'd31,         FN_SHL, 32'h8000_0000,  1'b0};
        vecs[8] = '{1'b0, 32'h8000_0000,  32'd31,         FN_SHR, 32'd1,          1'b0};
        vecs[9] = '{1'b1, 32'h8000_0000,  32'd4,          FN_SRA, 32'hF800_0000,  1'b0};

        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_fn = FN_ADD;
        bus.req1_valid = 1'b0; bus.req1_a = '0;    bus.req1_b = '0;    bus.req1_fn = '0;
        bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
        repeat (3) tick();

        // Reset state, with a request already pending.
        check("rst_busy",   64'(bus.busy),       64'd0);
        check("rst_rsp0_v", 64'(bus.rsp0_valid), 64'd0);
        check("rst_rsp1_v", 64'(bus.rsp1_valid), 64'd0);
        check("rst_rsp_r",  64'(bus.rsp_r),      64'd0);
        check("rst_rsp_z",  64'(bus.rsp_z),      64'd0);
        check("rst_alu_a",  64'(alu_a),          64'd0);
        check("rst_alu_fn", 64'(alu_fn),         64'd0);
        check("rst_ready0", 64'(bus.req0_ready), 64'd0);
        drop_req(1'b0);
        reset = 1'b0;
        tick();
        check("idle_no_req_ready", 64'(bus.req0_ready | bus.req1_ready), 64'd0);

        // Table of single operations with latency and state checks.
        foreach (vecs[k]) begin
            tick();
            drive_req(vecs[k].port, vecs[k].a, vecs[k].b, vecs[k].fn, vecs[k].r, vecs[k].z);
            wait_accept(vecs[k].port);
            drop_req(vecs[k].port);
            @(negedge clk);
            check("exec_busy",  64'(bus.busy), 64'd1);
            check("exec_no_rsp", 64'(bus.rsp0_valid | bus.rsp1_valid), 64'd0);
            check("exec_alu_a", 64'(alu_a), 64'(vecs[k].a));
            @(negedge clk);
            check("lat_rsp_v", 64'(vecs[k].port ? bus.rsp1_valid : bus.rsp0_valid), 64'd1);
            @(negedge clk);
            check("back_idle", 64'(bus.busy), 64'd0);
        end

        // Tie right after reset: port 0 first, port 1 back-to-back.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        sb.delete(); clear_logs();
        drive_req(1'b0, 32'd7, 32'd7, FN_SUB, 32'd0, 1'b1);
        drive_req(1'b1, 32'h0000_00F0, 32'h0000_000F, FN_OR, 32'h0000_00FF, 1'b0);
        run_both_once();
        if (grant_log.size() == 2) begin
            check("tie_first",  64'(grant_log[0]), 64'd0);
            check("tie_second", 64'(grant_log[1]), 64'd1);
            check("tie_b2b",    64'(acc_cycle[1] - acc_cycle[0]), 64'd2);
        end

        // Fairness: both requesters keep valid high for six operations.
        begin
            int issued;
            clear_logs();
            drive_req(1'b0, 32'd0, 32'd3, FN_ADD, 32'd3, 1'b0);
            drive_req(1'b1, 32'd1, 32'd3, FN_ADD, 32'd4, 1'b0);
            issued = 2;
            for (int i = 0; i < 60; i++) begin
                tick();
                for (int p = 0; p < 2; p++) begin
                    if (acc_now[p]) begin
                        if (issued < 6) begin
                            drive_req(1'(p), N'(issued), 32'd3, FN_ADD, N'(issued + 3), 1'b0);
                            issued++;
                        end else begin
                            drop_req(1'(p));
                        end
                    end
                end
                if (!bus.req0_valid && !bus.req1_valid && sb.size() == 0 && !bus.busy) break;
            end
            check("fair_count", 64'(grant_log.size()), 64'd6);
            for (int g = 0; g < 6 && g < grant_log.size(); g++)
                check("fair_order", 64'(grant_log[g]), 64'(g % 2));
            for (int g = 1; g < 6 && g < acc_cycle.size(); g++)
                check("fair_gap", 64'(acc_cycle[g] - acc_cycle[g-1]), 64'd2);
        end

        // Backpressure on port 1 while port 0 waits.
        bus.rsp1_ready = 1'b0;
        drive_req(1'b1, 32'h0000_1234, 32'h0000_1111, FN_SUB, 32'h0000_0123, 1'b0);
        wait_accept(1'b1);
        drop_req(1'b1);
        wait_rsp_valid(1'b1);
        drive_req(1'b0, 32'd9, 32'd1, FN_ADD, 32'd10, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_rsp1_v",  64'(bus.rsp1_valid), 64'd1);
            check("bp_rsp0_v",  64'(bus.rsp0_valid), 64'd0);
            check("bp_rsp_r",   64'(bus.rsp_r),      64'h123);
            check("bp_ready0",  64'(bus.req0_ready), 64'd0);
        end
        tick();
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready0", 64'(bus.req0_ready), 64'd1);
        wait_accept(1'b0);
        drop_req(1'b0);
        wait_idle();

        // Operands change right after accept.
        drive_req(1'b0, 32'd5, 32'd3, FN_ADD, 32'd8, 1'b0);
        wait_accept(1'b0);
        drop_req(1'b0);
        bus.req0_a = 32'd100; bus.req0_b = 32'd200; bus.req0_fn = FN_SUB;
        @(negedge clk);
        check("opchg_alu_a",  64'(alu_a),  64'd5);
        check("opchg_alu_b",  64'(alu_b),  64'd3);
        check("opchg_alu_fn", 64'(alu_fn), 64'(FN_ADD));
        wait_idle();

        // Reset in the middle of a held response.
        bus.rsp0_ready = 1'b0;
        drive_req(1'b0, 32'd6, 32'd6, FN_ADD, 32'd12, 1'b0);
        wait_accept(1'b0);
        drop_req(1'b0);
        wait_rsp_valid(1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_rsp0_v", 64'(bus.rsp0_valid), 64'd0);
        check("mid_rst_busy",   64'(bus.busy),       64'd0);
        @(negedge clk);
        check("mid_rst_rsp_r",  64'(bus.rsp_r),      64'd0);
        check("mid_rst_busy2",  64'(bus.busy),       64'd0);
        sb.delete();
        tick();
        reset = 1'b0;
        bus.rsp0_ready = 1'b1;
        tick();
        clear_logs();
        drive_req(1'b0, 32'd1, 32'd1, FN_ADD, 32'd2, 1'b0);
        drive_req(1'b1, 32'd2, 32'd2, FN_ADD, 32'd4, 1'b0);
        run_both_once();
        if (grant_log.size() == 2)
            check("post_rst_tie", 64'(grant_log[0]), 64'd0);

        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
